// File: rtl/clock_prog_ctrl_pkg.sv
// Shared types and constants for the clock programming controller.
package clock_prog_pkg;

  typedef enum logic [1:0] {
    DEFAULT     = 2'd0,
    NON_DEFAULT = 2'd1,
    DEFAULT0    = 2'd2,
    DEFAULT1    = 2'd3
  } clk_mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RESTORE   = 3'd4,
    DONE      = 3'd5
  } prog_state_e;

  localparam logic [7:0] DEFAULT_DIV = 8'd1;

endpackage

// File: rtl/clock_prog_ctrl_if.sv
// Request/programming/status bundle between a requester and the controller.
import clock_prog_pkg::*;

interface clock_prog_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  clk_mode_e  req_mode;
  logic [7:0] req_div;
  logic       prog_en;
  clk_mode_e  prog_mode;
  logic [7:0] prog_div;
  logic       lock_in;
  logic       busy;
  logic       done;
  logic       err;
  clk_mode_e  cur_mode;

  modport slave (
    input  req_valid, req_mode, req_div, lock_in,
    output req_ready, prog_en, prog_mode, prog_div, busy, done, err, cur_mode
  );

  modport master (
    output req_valid, req_mode, req_div, lock_in,
    input  req_ready, prog_en, prog_mode, prog_div, busy, done, err, cur_mode
  );
endinterface

// File: rtl/clock_prog_ctrl_prog_timer.sv
// Saturating up-counter with synchronous clear and terminal-count compare at LIMIT-1.
module prog_timer #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic Resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int W = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TC_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/clock_prog_ctrl.sv
// Sequences a clock generator reprogram: load, wait for lock, settle, and
// fall back to the previous setting if lock never arrives.
//
// state     | meaning
// IDLE      | ready for a request
// LOAD      | prog_en strobe with the new setting
// WAIT_LOCK | waiting for lock_in, timeout counter running
// SETTLE    | lock_in must stay high SETTLE_CYCLES cycles
// RESTORE   | reload backup setting, err pulse
// DONE      | done pulse, cur_mode updated
import clock_prog_pkg::*;

module clock_prog_ctrl #(
  parameter int LOCK_TIMEOUT  = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              Resetn,
  clock_prog_ctrl_if.slave  bus
);

  prog_state_e r_state;
  prog_state_e w_next;

  logic       r_ready_en;
  logic       r_err_ill;
  clk_mode_e  r_prog_mode;
  logic [7:0] r_prog_div;
  clk_mode_e  r_bak_mode;
  logic [7:0] r_bak_div;
  clk_mode_e  r_cur_mode;

  logic w_ready;
  logic w_accept;
  logic w_legal;
  logic w_to_clear;
  logic w_to_en;
  logic w_to_tc;
  logic w_st_clear;
  logic w_st_en;
  logic w_st_tc;

  // Ready is held off until the first edge after reset release.
  assign w_ready  = (r_state == IDLE) && r_ready_en;
  assign w_accept = bus.req_valid && w_ready;
  assign w_legal  = w_accept && (bus.req_div != 8'd0);

  assign w_to_clear = (r_state != WAIT_LOCK);
  assign w_to_en    = (r_state == WAIT_LOCK) && !bus.lock_in;
  assign w_st_clear = (r_state != SETTLE);
  assign w_st_en    = (r_state == SETTLE) && bus.lock_in;

  prog_timer #(.LIMIT(LOCK_TIMEOUT)) u_timeout (
    .clock    (clock),
    .Resetn   (Resetn),
    .i_clear  (w_to_clear),
    .i_enable (w_to_en),
    .o_tc     (w_to_tc)
  );

  prog_timer #(.LIMIT(SETTLE_CYCLES)) u_settle (
    .clock    (clock),
    .Resetn   (Resetn),
    .i_clear  (w_st_clear),
    .i_enable (w_st_en),
    .o_tc     (w_st_tc)
  );

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_legal) w_next = LOAD;
      LOAD:      w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (bus.lock_in)  w_next = SETTLE;
        else if (w_to_tc) w_next = RESTORE;
      end
      SETTLE: begin
        if (!bus.lock_in) w_next = WAIT_LOCK;
        else if (w_st_tc) w_next = DONE;
      end
      RESTORE:   w_next = IDLE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ready_en  <= 1'b0;
      r_err_ill   <= 1'b0;
      r_prog_mode <= DEFAULT;
      r_prog_div  <= DEFAULT_DIV;
      r_bak_mode  <= DEFAULT;
      r_bak_div   <= DEFAULT_DIV;
      r_cur_mode  <= DEFAULT;
    end else begin
      r_ready_en <= 1'b1;
      r_err_ill  <= w_accept && (bus.req_div == 8'd0);
      if (w_legal) begin
        r_bak_mode  <= r_prog_mode;
        r_bak_div   <= r_prog_div;
        r_prog_mode <= bus.req_mode;
        r_prog_div  <= bus.req_div;
      end else if ((r_state == WAIT_LOCK) && (w_next == RESTORE)) begin
        r_prog_mode <= r_bak_mode;
        r_prog_div  <= r_bak_div;
      end
      if (r_state == DONE) begin
        r_cur_mode <= r_prog_mode;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.prog_en   = (r_state == LOAD) || (r_state == RESTORE);
  assign bus.prog_mode = r_prog_mode;
  assign bus.prog_div  = r_prog_div;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.err       = (r_state == RESTORE) || r_err_ill;
  assign bus.cur_mode  = r_cur_mode;

endmodule

// File: tb/tb_clock_prog_ctrl.sv
// Directed self-checking bench for clock_prog_ctrl.
import clock_prog_pkg::*;

module tb_clock_prog_ctrl;

  logic clock;
  logic Resetn;
  int   checks;
  int   errors;

  clock_prog_ctrl_if bus ();

  clock_prog_ctrl #(.LOCK_TIMEOUT(64), .SETTLE_CYCLES(4)) dut (
    .clock  (clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input clk_mode_e m, input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_div   = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    Resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_mode  = DEFAULT;
    bus.req_div   = 8'd0;
    bus.lock_in   = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0 || bus.prog_en !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b prog_en=%b done=%b err=%b, required 0 0 0 0 0",
               bus.req_ready, bus.busy, bus.prog_en, bus.done, bus.err);
    end
    checks++;
    if (bus.prog_mode !== DEFAULT || bus.prog_div !== 8'd1 || bus.cur_mode !== DEFAULT) begin
      errors++;
      $display("FAIL reset_cfg: prog_mode=%0d prog_div=%0d cur_mode=%0d, required 0 1 0",
               bus.prog_mode, bus.prog_div, bus.cur_mode);
    end
    @(negedge clock);
    Resetn = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: req_ready=%b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_illegal();
    start_req(NON_DEFAULT, 8'd0);
    checks++;
    if (bus.err !== 1'b1 || bus.prog_en !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: err=%b prog_en=%b done=%b, required 1 0 0",
               bus.err, bus.prog_en, bus.done);
    end
    checks++;
    if (bus.prog_div !== 8'd1 || bus.prog_mode !== DEFAULT || bus.req_ready !== 1'b1 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_state: div=%0d mode=%0d ready=%b busy=%b, required 1 0 1 0",
               bus.prog_div, bus.prog_mode, bus.req_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.cur_mode !== DEFAULT) begin
      errors++;
      $display("FAIL illegal_one_cycle: err=%b cur_mode=%0d, required 0 0", bus.err, bus.cur_mode);
    end
  endtask

  task automatic test_basic();
    int cyc, pe_cnt, err_cnt, done_cyc;
    bus.lock_in = 1'b1;
    start_req(NON_DEFAULT, 8'd4);
    cyc = 1;
    checks++;
    if (bus.prog_en !== 1'b1 || bus.prog_mode !== NON_DEFAULT || bus.prog_div !== 8'd4 ||
        bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: prog_en=%b mode=%0d div=%0d ready=%b busy=%b, required 1 1 4 0 1",
               bus.prog_en, bus.prog_mode, bus.prog_div, bus.req_ready, bus.busy);
    end
    pe_cnt   = 1;
    err_cnt  = bus.err ? 1 : 0;
    done_cyc = -1;
    for (int i = 0; i < 20 && done_cyc < 0; i++) begin
      tick();
      cyc++;
      if (bus.prog_en) pe_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done) done_cyc = cyc;
    end
    checks++;
    if (done_cyc != 7) begin
      errors++;
      $display("FAIL basic_done_cycle: done at cycle %0d, required 7", done_cyc);
    end
    checks++;
    if (pe_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_strobes: prog_en count %0d err count %0d, required 1 0", pe_cnt, err_cnt);
    end
    tick();
    checks++;
    if (bus.cur_mode !== NON_DEFAULT || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_applied: cur_mode=%0d done=%b busy=%b, required 1 0 0",
               bus.cur_mode, bus.done, bus.busy);
    end
  endtask

  task automatic test_settle_restart();
    int cyc, done_cyc;
    bus.lock_in = 1'b1;
    start_req(DEFAULT0, 8'd6);
    cyc      = 1;
    done_cyc = -1;
    for (int i = 0; i < 30 && done_cyc < 0; i++) begin
      tick();
      cyc++;
      if (bus.done) done_cyc = cyc;
      bus.lock_in = (cyc == 5) ? 1'b0 : 1'b1;
    end
    checks++;
    if (done_cyc != 11) begin
      errors++;
      $display("FAIL settle_restart_done: done at cycle %0d, required 11", done_cyc);
    end
    tick();
    checks++;
    if (bus.cur_mode !== DEFAULT0) begin
      errors++;
      $display("FAIL settle_restart_mode: cur_mode=%0d, required 2", bus.cur_mode);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, pe_cnt, done_cyc;
    bus.lock_in = 1'b0;
    start_req(DEFAULT1, 8'd7);
    cyc      = 1;
    pe_cnt   = 1;
    done_cyc = -1;
    for (int i = 0; i < 30 && done_cyc < 0; i++) begin
      tick();
      cyc++;
      if (bus.prog_en) pe_cnt++;
      if (bus.done) done_cyc = cyc;
      if (cyc == 3) begin
        bus.req_valid = 1'b1;
        bus.req_mode  = DEFAULT0;
        bus.req_div   = 8'd2;
      end
      if (cyc == 4) begin
        checks++;
        if (bus.req_ready !== 1'b0 || bus.prog_mode !== DEFAULT1 || bus.prog_div !== 8'd7) begin
          errors++;
          $display("FAIL busy_ready: ready=%b mode=%0d div=%0d, required 0 3 7",
                   bus.req_ready, bus.prog_mode, bus.prog_div);
        end
      end
      if (cyc == 5) bus.lock_in = 1'b1;
      if (cyc == 6) bus.req_valid = 1'b0;
    end
    checks++;
    if (done_cyc != 10 || pe_cnt != 1) begin
      errors++;
      $display("FAIL busy_ignore: done cycle %0d prog_en count %0d, required 10 1", done_cyc, pe_cnt);
    end
    tick();
    checks++;
    if (bus.cur_mode !== DEFAULT1 || bus.prog_div !== 8'd7 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_applied: cur_mode=%0d div=%0d busy=%b, required 3 7 0",
               bus.cur_mode, bus.prog_div, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int cyc, pe_cnt, done_cnt, err_cyc;
    logic pe_at_err;
    clk_mode_e mode_at_err;
    logic [7:0] div_at_err;
    // Current applied setting is DEFAULT1/div 7; reapply DEFAULT1/div 3 first.
    bus.lock_in = 1'b1;
    start_req(DEFAULT1, 8'd3);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (bus.cur_mode !== DEFAULT1 || bus.prog_div !== 8'd3 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_setup: cur_mode=%0d div=%0d busy=%b, required 3 3 0",
               bus.cur_mode, bus.prog_div, bus.busy);
    end
    bus.lock_in = 1'b0;
    start_req(DEFAULT0, 8'd9);
    cyc = 1;
    checks++;
    if (bus.prog_en !== 1'b1 || bus.prog_mode !== DEFAULT0 || bus.prog_div !== 8'd9) begin
      errors++;
      $display("FAIL timeout_load: prog_en=%b mode=%0d div=%0d, required 1 2 9",
               bus.prog_en, bus.prog_mode, bus.prog_div);
    end
    pe_cnt      = 1;
    done_cnt    = 0;
    err_cyc     = -1;
    pe_at_err   = 1'b0;
    mode_at_err = DEFAULT;
    div_at_err  = 8'd0;
    for (int i = 0; i < 120 && err_cyc < 0; i++) begin
      tick();
      cyc++;
      if (bus.prog_en) pe_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err) begin
        err_cyc     = cyc;
        pe_at_err   = bus.prog_en;
        mode_at_err = bus.prog_mode;
        div_at_err  = bus.prog_div;
      end
    end
    checks++;
    if (err_cyc != 66) begin
      errors++;
      $display("FAIL timeout_cycle: err at cycle %0d, required 66", err_cyc);
    end
    checks++;
    if (pe_at_err !== 1'b1 || mode_at_err !== DEFAULT1 || div_at_err !== 8'd3) begin
      errors++;
      $display("FAIL timeout_restore: prog_en=%b mode=%0d div=%0d, required 1 3 3",
               pe_at_err, mode_at_err, div_at_err);
    end
    checks++;
    if (pe_cnt != 2 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_strobes: prog_en count %0d done count %0d, required 2 0", pe_cnt, done_cnt);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.cur_mode !== DEFAULT1 ||
        bus.prog_div !== 8'd3) begin
      errors++;
      $display("FAIL timeout_after: err=%b busy=%b cur_mode=%0d div=%0d, required 0 0 3 3",
               bus.err, bus.busy, bus.cur_mode, bus.prog_div);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus.lock_in = 1'b1;
    start_req(NON_DEFAULT, 8'd5);
    tick(); tick(); tick();
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.prog_mode !== DEFAULT || bus.prog_div !== 8'd1 ||
        bus.req_ready !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: busy=%b mode=%0d div=%0d ready=%b done=%b err=%b, required 0 0 1 0 0 0",
               bus.busy, bus.prog_mode, bus.prog_div, bus.req_ready, bus.done, bus.err);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.err) pulses++;
    end
    @(negedge clock);
    Resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.err || bus.prog_en) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.req_ready !== 1'b1 || bus.cur_mode !== DEFAULT) begin
      errors++;
      $display("FAIL midreset_after: pulses=%0d ready=%b cur_mode=%0d, required 0 1 0",
               pulses, bus.req_ready, bus.cur_mode);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_illegal();
    test_basic();
    test_settle_restart();
    test_busy_ignore();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
